// File: rtl/led_status_ctrl.sv
// Multi-channel front-panel LED driver: shared ms prescaler and blink counter,
// per-channel mode select with steady, blink and event-stretch behaviours.
module led_status_ctrl #(
    parameter int NCH        = 4,
    parameter int TICK_DIV   = 2500,
    parameter int HOLD_MS    = 64,
    parameter int SLOW_BIT   = 8,
    parameter int FAST_BIT   = 6,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3*NCH-1:0]   mode,
    input  logic [NCH-1:0]     sig,
    input  logic               lamp_test,
    output logic               ms_pulse,
    output logic [NCH-1:0]     led
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(HOLD_MS + 1);
    localparam int BW = SLOW_BIT + 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_PRE = PW'(TICK_DIV - 2);
    localparam logic [CW-1:0] HOLD_VAL  = CW'(HOLD_MS);

    localparam logic [2:0] M_ON      = 3'b001;
    localparam logic [2:0] M_SLOW    = 3'b010;
    localparam logic [2:0] M_FAST    = 3'b011;
    localparam logic [2:0] M_RETRIG  = 3'b100;
    localparam logic [2:0] M_ONESHOT = 3'b101;
    localparam logic [2:0] M_SBLINK  = 3'b110;

    logic [PW-1:0]  presc_q, presc_d;
    logic           ms_pulse_q, ms_pulse_d;
    logic [BW-1:0]  bcnt_q, bcnt_d;
    logic [NCH-1:0] led_q, led_d;
    logic [NCH-1:0] lit;
    logic           slow_ph, fast_ph;

    assign slow_ph = bcnt_q[SLOW_BIT];
    assign fast_ph = bcnt_q[FAST_BIT];

    // The strobe is registered one count early so it is high while count==TICK_DIV-1.
    always_comb begin
        presc_d    = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
        ms_pulse_d = (presc_q == PRESC_PRE);
        bcnt_d     = ms_pulse_q ? bcnt_q + BW'(1) : bcnt_q;
        led_d      = (lit | {NCH{lamp_test}}) ^ {NCH{ACTIVE_LOW}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            ms_pulse_q <= 1'b0;
            bcnt_q     <= '0;
            led_q      <= {NCH{ACTIVE_LOW}};
        end else begin
            presc_q    <= presc_d;
            ms_pulse_q <= ms_pulse_d;
            bcnt_q     <= bcnt_d;
            led_q      <= led_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [2:0]    ch_mode;
            logic [CW-1:0] cnt_q, cnt_d;
            logic          ch_lit;

            assign ch_mode = mode[3*gi +: 3];

            // A load always beats a same-cycle decrement; non-stretch modes park the counter at 0.
            always_comb begin
                cnt_d = cnt_q;
                case (ch_mode)
                    M_RETRIG, M_SBLINK: begin
                        if (sig[gi])
                            cnt_d = HOLD_VAL;
                        else if (ms_pulse_q && (cnt_q != '0))
                            cnt_d = cnt_q - CW'(1);
                    end
                    M_ONESHOT: begin
                        if (sig[gi] && (cnt_q == '0))
                            cnt_d = HOLD_VAL;
                        else if (ms_pulse_q && (cnt_q != '0))
                            cnt_d = cnt_q - CW'(1);
                    end
                    default: cnt_d = '0;
                endcase
            end

            always_comb begin
                ch_lit = 1'b0;
                case (ch_mode)
                    M_ON:                ch_lit = 1'b1;
                    M_SLOW:              ch_lit = slow_ph;
                    M_FAST:              ch_lit = fast_ph;
                    M_RETRIG, M_ONESHOT: ch_lit = (cnt_q != '0);
                    M_SBLINK:            ch_lit = (cnt_q != '0) && fast_ph;
                    default:             ch_lit = 1'b0;
                endcase
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    cnt_q <= '0;
                else
                    cnt_q <= cnt_d;
            end

            assign lit[gi] = ch_lit;
        end
    endgenerate

    assign ms_pulse = ms_pulse_q;
    assign led      = led_q;

endmodule
